// File: rtl/adc_temp_logger_if.sv
// ADC response / RAM write / LED bundle for adc_temp_logger.
// master: ADC-side driver and observer; slave: the logger itself.
interface adc_temp_logger_if #(
   parameter int SAMPLE_W = 12,
   parameter int ADDR_W   = 8
);
   logic                sample_valid;
   logic [SAMPLE_W-1:0] sample_data;
   logic [ADDR_W-1:0]   ram_addr;
   logic [SAMPLE_W-1:0] ram_data;
   logic                ram_wren;
   logic [7:0]          led_dout;
   logic                avg_valid;
   logic                buf_wrapped;

   modport master (
      output sample_valid, sample_data,
      input  ram_addr, ram_data, ram_wren,
      input  led_dout, avg_valid, buf_wrapped
   );

   modport slave (
      input  sample_valid, sample_data,
      output ram_addr, ram_data, ram_wren,
      output led_dout, avg_valid, buf_wrapped
   );
endinterface

// File: rtl/adc_temp_logger.sv
// Block-averages 2^LOG2_AVG ADC samples, writes each average to a wrapping
// RAM address and shows its top 8 bits on the LEDs.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   sample_valid/sample_data in; ram_addr/ram_data/ram_wren,
//   led_dout, avg_valid, buf_wrapped out (all registered).
module adc_temp_logger #(
   parameter int SAMPLE_W = 12,
   parameter int LOG2_AVG = 4,
   parameter int ADDR_W   = 8
) (
   input logic              clk,
   input logic              rst,
   adc_temp_logger_if.slave bus
);
   localparam int ACC_W = SAMPLE_W + LOG2_AVG;

   typedef enum logic {ACCUM, WRITE} state_t;

   state_t              state;
   logic [ACC_W-1:0]    acc;
   logic [LOG2_AVG-1:0] cnt;
   logic [ADDR_W-1:0]   addr_q;
   logic [SAMPLE_W-1:0] data_q;
   logic                wren_q;
   logic [7:0]          led_q;
   logic                wrap_q;

   logic [ACC_W-1:0]    smp_ext;
   logic [ACC_W-1:0]    sum;
   logic [SAMPLE_W-1:0] avg;

   assign smp_ext = {{LOG2_AVG{1'b0}}, bus.sample_data};
   assign sum     = acc + smp_ext;
   // Truncating divide by 2^LOG2_AVG.
   assign avg     = sum[ACC_W-1:LOG2_AVG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ACCUM;
         acc    <= '0;
         cnt    <= '0;
         addr_q <= '0;
         data_q <= '0;
         wren_q <= 1'b0;
         led_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (bus.sample_valid) begin
                  if (cnt == {LOG2_AVG{1'b1}}) begin
                     data_q <= avg;
                     led_q  <= avg[SAMPLE_W-1 -: 8];
                     wren_q <= 1'b1;
                     acc    <= '0;
                     cnt    <= '0;
                     state  <= WRITE;
                  end else begin
                     acc <= sum;
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            WRITE: begin
               wren_q <= 1'b0;
               addr_q <= addr_q + 1'b1;
               if (&addr_q) wrap_q <= 1'b1;
               // A sample arriving here opens the next window.
               if (bus.sample_valid) begin
                  acc <= smp_ext;
                  cnt <= {{(LOG2_AVG-1){1'b0}}, 1'b1};
               end else begin
                  acc <= '0;
                  cnt <= '0;
               end
               state <= ACCUM;
            end
            default: state <= ACCUM;
         endcase
      end
   end

   assign bus.ram_addr    = addr_q;
   assign bus.ram_data    = data_q;
   assign bus.ram_wren    = wren_q;
   assign bus.avg_valid   = wren_q;
   assign bus.led_dout    = led_q;
   assign bus.buf_wrapped = wrap_q;
endmodule

// File: tb/tb_adc_temp_logger.sv
// Directed bench for adc_temp_logger (SAMPLE_W=12, LOG2_AVG=4, ADDR_W=8).
// Writes seen on ram_wren are queued and compared against hand values.
module tb_adc_temp_logger;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   errors  = 0;
   logic prev_wren = 1'b0;
   logic [7:0]  qa[$];
   logic [11:0] qd[$];

   always #5 clk = ~clk;

   adc_temp_logger_if #(.SAMPLE_W(12), .ADDR_W(8)) bus ();

   adc_temp_logger #(
      .SAMPLE_W(12),
      .LOG2_AVG(4),
      .ADDR_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic v, input logic [11:0] d);
      bus.sample_valid = v;
      bus.sample_data  = d;
      @(posedge clk);
      #1;
      if (bus.ram_wren) begin
         chk("wren_width", {31'd0, prev_wren}, 32'd0);
         chk("avg_valid", {31'd0, bus.avg_valid}, 32'd1);
         qa.push_back(bus.ram_addr);
         qd.push_back(bus.ram_data);
      end
      prev_wren = bus.ram_wren;
   endtask

   task automatic feed(input int n, input logic [11:0] d);
      for (int i = 0; i < n; i++) tick(1'b1, d);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, {24'd0, bus.ram_addr}, 32'd0);
      chk({tag, "_data"}, {20'd0, bus.ram_data}, 32'd0);
      chk({tag, "_wren"}, {31'd0, bus.ram_wren}, 32'd0);
      chk({tag, "_led"}, {24'd0, bus.led_dout}, 32'd0);
      chk({tag, "_avgv"}, {31'd0, bus.avg_valid}, 32'd0);
      chk({tag, "_wrap"}, {31'd0, bus.buf_wrapped}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0, 12'h000);
      rst = 1'b0;
      qa.delete();
      qd.delete();
   endtask

   initial begin
      bus.sample_valid = 1'b0;
      bus.sample_data  = '0;

      // Held in reset: samples must have no effect.
      feed(20, 12'h800);
      chk_zero("rst_hold");
      chk("rst_nowr", qa.size(), 32'd0);

      // First window after release.
      rst = 1'b0;
      feed(16, 12'h800);
      chk("w1_wren", {31'd0, bus.ram_wren}, 32'd1);
      chk("w1_addr", {24'd0, bus.ram_addr}, 32'h0);
      chk("w1_data", {20'd0, bus.ram_data}, 32'h800);
      chk("w1_led", {24'd0, bus.led_dout}, 32'h80);
      tick(1'b0, 12'h000);
      chk("w1_wren_off", {31'd0, bus.ram_wren}, 32'd0);
      chk("w1_addr_inc", {24'd0, bus.ram_addr}, 32'h1);
      chk("w1_count", qa.size(), 32'd1);

      // Truncation and full-scale without overflow.
      feed(15, 12'h000);
      feed(1, 12'h00F);
      chk("trunc_data", {20'd0, bus.ram_data}, 32'h000);
      chk("trunc_addr", {24'd0, bus.ram_addr}, 32'h1);
      tick(1'b0, 12'h000);
      feed(16, 12'hFFF);
      chk("full_data", {20'd0, bus.ram_data}, 32'hFFF);
      chk("full_led", {24'd0, bus.led_dout}, 32'hFF);
      tick(1'b0, 12'h000);

      // Back-to-back samples 0..63 straight through the write cycles.
      do_reset();
      chk_zero("rst_pulse");
      for (int i = 0; i < 64; i++) tick(1'b1, 12'(i));
      tick(1'b0, 12'h000);
      chk("b2b_count", qa.size(), 32'd4);
      if (qa.size() == 4) begin
         chk("b2b_a0", {24'd0, qa[0]}, 32'd0);
         chk("b2b_a1", {24'd0, qa[1]}, 32'd1);
         chk("b2b_a2", {24'd0, qa[2]}, 32'd2);
         chk("b2b_a3", {24'd0, qa[3]}, 32'd3);
         chk("b2b_d0", {20'd0, qd[0]}, 32'd7);
         chk("b2b_d1", {20'd0, qd[1]}, 32'd23);
         chk("b2b_d2", {20'd0, qd[2]}, 32'd39);
         chk("b2b_d3", {20'd0, qd[3]}, 32'd55);
      end
      chk("b2b_led", {24'd0, bus.led_dout}, 32'h03);

      // Sparse: samples 0x100+i with random idle gaps; avg 0x107.
      qa.delete();
      qd.delete();
      for (int i = 0; i < 16; i++) begin
         int gap;
         gap = int'($urandom_range(36, 0));
         for (int g = 0; g < gap; g++) tick(1'b0, 12'hABC);
         if (i == 15) begin
            chk("sp_led_hold", {24'd0, bus.led_dout}, 32'h03);
            chk("sp_none_yet", qa.size(), 32'd0);
         end
         tick(1'b1, 12'(12'h100 + i));
      end
      chk("sp_wren", {31'd0, bus.ram_wren}, 32'd1);
      chk("sp_addr", {24'd0, bus.ram_addr}, 32'd4);
      chk("sp_data", {20'd0, bus.ram_data}, 32'h107);
      chk("sp_led", {24'd0, bus.led_dout}, 32'h10);
      tick(1'b0, 12'h000);
      chk("sp_wren_off", {31'd0, bus.ram_wren}, 32'd0);

      // Wrap: 257 windows, window w has average w.
      do_reset();
      for (int w = 0; w < 257; w++) begin
         feed(16, 12'(w));
         if (w == 255) begin
            chk("wrap_pre", {31'd0, bus.buf_wrapped}, 32'd0);
            chk("wrap_a255", {24'd0, bus.ram_addr}, 32'd255);
         end
      end
      chk("wrap_set", {31'd0, bus.buf_wrapped}, 32'd1);
      chk("wrap_count", qa.size(), 32'd257);
      if (qa.size() == 257) begin
         for (int k = 0; k < 257; k++) begin
            chk($sformatf("wrap_a%0d", k), {24'd0, qa[k]}, 32'(k % 256));
            chk($sformatf("wrap_d%0d", k), {20'd0, qd[k]}, 32'(k));
         end
      end
      tick(1'b0, 12'h000);
      tick(1'b0, 12'h000);
      chk("wrap_sticky", {31'd0, bus.buf_wrapped}, 32'd1);

      // Async reset mid-window discards the partial sum.
      do_reset();
      feed(10, 12'hABC);
      rst = 1'b1;
      #2;
      chk_zero("mid_async");
      tick(1'b0, 12'h000);
      rst = 1'b0;
      qa.delete();
      qd.delete();
      feed(16, 12'h100);
      tick(1'b0, 12'h000);
      chk("mid_count", qa.size(), 32'd1);
      if (qa.size() == 1) begin
         chk("mid_addr", {24'd0, qa[0]}, 32'd0);
         chk("mid_data", {20'd0, qd[0]}, 32'h100);
      end

      // Async reset during the write cycle suppresses it.
      feed(16, 12'h200);
      chk("wr_rst_pre", {31'd0, bus.ram_wren}, 32'd1);
      rst = 1'b1;
      #2;
      chk_zero("wr_async");
      tick(1'b0, 12'h000);
      rst = 1'b0;
      tick(1'b0, 12'h000);
      chk("wr_rst_addr", {24'd0, bus.ram_addr}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/adc_temp_logger.md
# adc_temp_logger

Downstream consumer of the on-chip ADC sequencer response stream in the temperature-readout design. Block-averages 2^LOG2_AVG consecutive 12-bit samples, writes each average into the sample RAM at an auto-incrementing, wrapping address, and drives the 8-bit LED display with the most-significant bits of the latest average. Sits between the ADC response port (valid/data) and the single-port RAM write port and LED pins.

## Interface
- SAMPLE_W, 12, ADC sample width
- LOG2_AVG, 4, log2 of samples per average (1..8)
- ADDR_W, 8, RAM address width; buffer depth 2^ADDR_W
- clk  in  1  system clock (same clock as ADC CSR/response interface)
- rst  in  1  asynchronous, active-high reset
- sample_valid  in  1  ADC response valid; one-cycle pulse per sample
- sample_data  in  SAMPLE_W  ADC response data, valid when sample_valid=1
- ram_addr  out  ADDR_W  RAM write address
- ram_data  out  SAMPLE_W  RAM write data (average)
- ram_wren  out  1  RAM write enable, one-cycle pulse
- led_dout  out  8  latest average, bits [SAMPLE_W-1:SAMPLE_W-8]
- avg_valid  out  1  one-cycle pulse coincident with ram_wren
- buf_wrapped  out  1  sticky; set on first address wrap

## Operation
- Reset values: ram_addr=0, ram_data=0, ram_wren=0, led_dout=0, avg_valid=0, buf_wrapped=0; accumulator=0, sample count=0, state=ACCUM.
- Accumulator width SAMPLE_W+LOG2_AVG; never overflows (max (2^SAMPLE_W-1)*2^LOG2_AVG).
- FSM states: ACCUM, WRITE.
- ACCUM: on sample_valid, acc += sample_data, cnt += 1. When accepted sample is number 2^LOG2_AVG (cnt == 2^LOG2_AVG-1 before accept): latch avg = (acc + sample_data) >> LOG2_AVG (truncating, no rounding) into ram_data and led_dout, assert ram_wren/avg_valid for next cycle, go to WRITE.
- WRITE (exactly one cycle): ram_wren=1, avg_valid=1, ram_addr holds current address. On exit, ram_addr increments modulo 2^ADDR_W; state returns to ACCUM with acc/cnt cleared.
- Sample during WRITE: not dropped; becomes first sample of next window (acc=sample_data, cnt=1).
- Wrap: when ram_addr increments from 2^ADDR_W-1 to 0, buf_wrapped sets; stays set until rst. Old entries are overwritten.
- ram_data and led_dout hold the last average between writes.
- sample_valid with no data change still counts; sample_data ignored when sample_valid=0.

## Timing
- Final sample of window accepted on edge T: ram_wren, avg_valid high for cycle T..T+1 (one clock), ram_data/led_dout updated at edge T, ram_addr increments at edge T+1.
- Latency final sample -> RAM write: 1 cycle. Minimum window period: 2^LOG2_AVG cycles (back-to-back valids sustained, no loss).
- All outputs registered; no combinational path input->output.
- rst asserted mid-window or during WRITE: all state and outputs return to reset values immediately (async); partial window discarded, pending write suppressed. Deassertion synchronised by standard reset release; first sample after release starts a fresh window.

## Test plan
- Reset: hold rst, drive valid samples -> all outputs 0, no ram_wren; release, 16 samples of 0x800 -> one ram_wren, ram_addr=0, ram_data=0x800, led_dout=0x80.
- Truncation: 15 samples 0x000 + 1 sample 0x00F -> ram_data=0x000; 16 samples 0xFFF -> ram_data=0xFFF, led_dout=0xFF (no overflow).
- Back-to-back: continuous sample_valid every cycle for 64 cycles, values 0..63 -> 4 writes at addr 0..3, data 7, 23, 39, 55; no sample lost, incl. samples coinciding with WRITE.
- Sparse input: valid every 37 cycles with random gaps -> writes only after each 16th valid, ram_wren width exactly 1 cycle, led_dout stable between writes.
- Wrap: 257 windows (ADDR_W=8) -> ram_addr sequence 0..255,0; buf_wrapped rises on increment 255->0 and stays 1.
- Mid-operation reset: assert rst after 10 samples, release, feed 16 samples of 0x100 -> single write at addr 0, data 0x100 (earlier partial sum discarded).
